// File: rtl/cdr_gain_scheduler.sv
// CDR loop-filter gain scheduler: judges lock from windowed bang-bang vote sums and
// steps gainsel ACQ -> SETTLE -> TRACK. Optional macro CDR_GAIN_OVERRIDE_EN adds a gain override.
module cdr_gain_scheduler #(
  parameter int         WIN_LOG2   = 6,
  parameter int         LOCK_THR   = 8,
  parameter int         LOCK_WINS  = 4,
  parameter int         UNLOCK_THR = 24,
  parameter logic [1:0] GAIN_ACQ   = 2'b11,
  parameter logic [1:0] GAIN_MID   = 2'b10,
  parameter logic [1:0] GAIN_TRK   = 2'b01
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       pd_valid,
  input  logic [1:0]                 pd_err,
`ifdef CDR_GAIN_OVERRIDE_EN
  input  logic                       gain_ovr_en,
  input  logic [1:0]                 gain_ovr_val,
`endif
  output logic [1:0]                 gainsel,
  output logic                       lf_clear,
  output logic                       locked,
  output logic [2:0]                 state,
  output logic signed [WIN_LOG2+1:0] win_net
);

  localparam int ACC_W = WIN_LOG2 + 2;
  localparam int BAL_W = $clog2(LOCK_WINS + 1);
  localparam logic [WIN_LOG2-1:0] CNT_LAST     = {WIN_LOG2{1'b1}};
  localparam logic [ACC_W-1:0]    LOCK_THR_V   = ACC_W'(LOCK_THR);
  localparam logic [ACC_W-1:0]    UNLOCK_THR_V = ACC_W'(UNLOCK_THR);
  localparam logic [BAL_W-1:0]    LOCK_WINS_V  = BAL_W'(LOCK_WINS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACQ    = 3'd2,
    S_SETTLE = 3'd3,
    S_TRACK  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [BAL_W-1:0]        bal_q, bal_d;
  logic signed [ACC_W-1:0] win_net_q, win_net_d;
  logic [1:0]              gainsel_q, gainsel_d;
  logic                    lf_clear_q, lf_clear_d;
  logic                    locked_q, locked_d;

  logic signed [ACC_W-1:0] vote_s, net_s;
  logic [ACC_W-1:0]        net_abs_s;
  logic                    running_s, win_end_s, balanced_s, unlock_s;
  logic [BAL_W-1:0]        bal_next_s;
  logic [1:0]              fsm_gain_s;

  function automatic logic signed [ACC_W-1:0] decode_vote(input logic [1:0] err);
    logic signed [ACC_W-1:0] v;
    case (err)
      2'b01:   v = ACC_W'(1);
      2'b11:   v = '1;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign vote_s     = decode_vote(pd_err);
  assign net_s      = acc_q + vote_s;
  assign net_abs_s  = net_s[ACC_W-1] ? $unsigned(-net_s) : $unsigned(net_s);
  assign running_s  = (state_q == S_ACQ) || (state_q == S_SETTLE) || (state_q == S_TRACK);
  assign win_end_s  = running_s && pd_valid && (cnt_q == CNT_LAST);
  assign balanced_s = (net_abs_s <= LOCK_THR_V);
  assign unlock_s   = (net_abs_s > UNLOCK_THR_V);
  // Balanced-window run length after this window, saturating at LOCK_WINS.
  assign bal_next_s = !balanced_s ? '0 :
                      (bal_q == LOCK_WINS_V) ? bal_q : (bal_q + BAL_W'(1));

  // Next state and registered-output decode; loss of enable overrides any window result.
  always_comb begin
    state_d    = state_q;
    fsm_gain_s = 2'b00;
    lf_clear_d = 1'b0;
    locked_d   = 1'b0;
    gainsel_d  = 2'b00;
    case (state_q)
      S_IDLE:   state_d = S_CLEAR;
      S_CLEAR:  state_d = S_ACQ;
      S_ACQ:    if (win_end_s && (bal_next_s == LOCK_WINS_V)) state_d = S_SETTLE;
                else state_d = S_ACQ;
      S_SETTLE: if (win_end_s && (bal_next_s == LOCK_WINS_V)) state_d = S_TRACK;
                else state_d = S_SETTLE;
      S_TRACK:  if (win_end_s && unlock_s) state_d = S_ACQ;
                else state_d = S_TRACK;
      default:  state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
    case (state_d)
      S_CLEAR:  begin fsm_gain_s = GAIN_ACQ; lf_clear_d = 1'b1; end
      S_ACQ:    fsm_gain_s = GAIN_ACQ;
      S_SETTLE: fsm_gain_s = GAIN_MID;
      S_TRACK:  begin fsm_gain_s = GAIN_TRK; locked_d = 1'b1; end
      default:  fsm_gain_s = 2'b00;
    endcase
`ifdef CDR_GAIN_OVERRIDE_EN
    if (gain_ovr_en && (state_d != S_IDLE)) begin
      gainsel_d = gain_ovr_val;
    end else begin
      gainsel_d = fsm_gain_s;
    end
`else
    gainsel_d = fsm_gain_s;
`endif
  end

  // Window counter, accumulator, balanced-run counter and captured window sum.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    bal_d     = bal_q;
    win_net_d = win_net_q;
    if (!enable || !running_s) begin
      cnt_d = '0;
      acc_d = '0;
      bal_d = '0;
    end else begin
      if (pd_valid) begin
        cnt_d = cnt_q + WIN_LOG2'(1);
        acc_d = win_end_s ? '0 : net_s;
      end else begin
        cnt_d = cnt_q;
        acc_d = acc_q;
      end
      if (win_end_s) begin
        win_net_d = net_s;
        bal_d     = bal_next_s;
      end else begin
        win_net_d = win_net_q;
        bal_d     = bal_q;
      end
      if (state_d != state_q) begin
        bal_d = '0;
      end else begin
        bal_d = bal_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      bal_q      <= '0;
      win_net_q  <= '0;
      gainsel_q  <= 2'b00;
      lf_clear_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      bal_q      <= bal_d;
      win_net_q  <= win_net_d;
      gainsel_q  <= gainsel_d;
      lf_clear_q <= lf_clear_d;
      locked_q   <= locked_d;
    end
  end

  assign state    = state_q;
  assign gainsel  = gainsel_q;
  assign lf_clear = lf_clear_q;
  assign locked   = locked_q;
  assign win_net  = win_net_q;

endmodule

// File: tb/tb_cdr_gain_scheduler.sv
// Bench for cdr_gain_scheduler: table of start-up vectors through a scoreboard queue,
// then hand-built vote windows for lock, unlock, hold and enable-drop corner cases.
module tb_cdr_gain_scheduler;

  logic              clk = 1'b0;
  logic              reset, enable, pd_valid;
  logic [1:0]        pd_err;
  logic [1:0]        gainsel;
  logic              lf_clear, locked;
  logic [2:0]        state;
  logic signed [7:0] win_net;

  int checks = 0;
  int failures = 0;
  int clr_pulses = 0;
  int clr_base;

  localparam logic [1:0] VP = 2'b01;
  localparam logic [1:0] VN = 2'b11;
  localparam logic [1:0] VZ = 2'b10;

  typedef struct packed {
    logic       en;
    logic       v;
    logic [1:0] err;
    logic [2:0] st;
    logic [1:0] gs;
    logic       clr;
    logic       lk;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  vec_t e;

  always #5 clk = ~clk;

  always @(posedge lf_clear) clr_pulses++;

  cdr_gain_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .pd_valid(pd_valid), .pd_err(pd_err),
    .gainsel(gainsel), .lf_clear(lf_clear), .locked(locked), .state(state), .win_net(win_net)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int st, input int gs, input int clr, input int lk);
    chk({name, ".state"}, int'(state), st);
    chk({name, ".gainsel"}, int'(gainsel), gs);
    chk({name, ".lf_clear"}, int'(lf_clear), clr);
    chk({name, ".locked"}, int'(locked), lk);
  endtask

  task automatic tick(input logic en, input logic v, input logic [1:0] err);
    enable = en;
    pd_valid = v;
    pd_err = err;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [1:0] err);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, err);
  endtask

  task automatic alt(input int n, input logic [1:0] first);
    logic [1:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b1, v);
      v = (v == VP) ? VN : VP;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; pd_valid = 1'b0; pd_err = 2'b00;
    @(negedge clk); @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.win_net", int'(win_net), 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++)
      vecs[i] = '{en: 1'b0, v: 1'b1, err: VP, st: 3'd0, gs: 2'b00, clr: 1'b0, lk: 1'b0};
    vecs[4] = '{en: 1'b1, v: 1'b0, err: 2'b00, st: 3'd1, gs: 2'b11, clr: 1'b1, lk: 1'b0};
    vecs[5] = '{en: 1'b1, v: 1'b1, err: VP,    st: 3'd2, gs: 2'b11, clr: 1'b0, lk: 1'b0};
    vecs[6] = '{en: 1'b1, v: 1'b0, err: VN,    st: 3'd2, gs: 2'b11, clr: 1'b0, lk: 1'b0};
    vecs[7] = '{en: 1'b1, v: 1'b0, err: VN,    st: 3'd2, gs: 2'b11, clr: 1'b0, lk: 1'b0};

    for (int i = 0; i < 8; i++) begin
      enable = vecs[i].en; pd_valid = vecs[i].v; pd_err = vecs[i].err;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk_out($sformatf("vec%0d", i), int'(e.st), int'(e.gs), int'(e.clr), int'(e.lk));
    end

    // ACQ: unbalanced windows, 2'b10 votes count as zero
    run(40, VP); run(24, VZ);
    chk("acq_mixed.win_net", int'(win_net), 40);
    chk("acq_mixed.state", int'(state), 2);
    run(64, VP);
    chk("acq_pos.win_net", int'(win_net), 64);
    chk("acq_pos.gainsel", int'(gainsel), 3);
    alt(192, VP);
    chk("acq_3bal.state", int'(state), 2);
    run(36, VP); run(27, VN);
    chk("acq_4th_pre.gainsel", int'(gainsel), 3);
    run(1, VN);
    chk("acq_4th.win_net", int'(win_net), 8);
    chk_out("to_settle", 3, 2, 0, 0);

    // SETTLE -> TRACK
    alt(255, VP);
    chk("settle_pre.state", int'(state), 3);
    alt(1, VN);
    chk_out("to_track", 4, 1, 0, 1);
    chk("to_track.win_net", int'(win_net), 0);

    // TRACK hold windows
    run(40, VP); run(24, VN);
    chk("trk16.win_net", int'(win_net), 16);
    chk_out("trk16", 4, 1, 0, 1);
    run(44, VP); run(20, VN);
    chk("trk24.win_net", int'(win_net), 24);
    chk("trk24.state", int'(state), 4);

    // TRACK unlock
    clr_base = clr_pulses;
    run(63, VN);
    chk("unlock_pre.state", int'(state), 4);
    run(1, VN);
    chk_out("unlock", 2, 3, 0, 0);
    chk("unlock.win_net", int'(win_net), -64);
    chk("unlock.no_clear", clr_pulses - clr_base, 0);

    // Back to SETTLE, then drop enable on the 4th balanced window end
    alt(256, VP);
    chk("resettle.state", int'(state), 3);
    alt(192, VP);
    alt(63, VP);
    chk("drop_pre.state", int'(state), 3);
    tick(1'b0, 1'b1, VN);
    chk_out("drop", 0, 0, 0, 0);

    // Re-enable: single clear pulse, fresh window
    clr_base = clr_pulses;
    tick(1'b1, 1'b1, VP);
    chk_out("reen_clear", 1, 3, 1, 0);
    tick(1'b1, 1'b1, VP);
    chk_out("reen_acq", 2, 3, 0, 0);
    chk("reen.pulses", clr_pulses - clr_base, 1);
    run(63, VP);
    chk("fresh_pre.win_net", int'(win_net), 0);
    run(1, VP);
    chk("fresh.win_net", int'(win_net), 64);

    // Asynchronous reset mid-operation
    run(10, VP);
    clr_base = clr_pulses;
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    chk("async_rst.win_net", int'(win_net), 0);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b00);
    chk_out("post_rst", 0, 0, 0, 0);
    chk("post_rst.pulses", clr_pulses - clr_base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdr_gain_scheduler.md
Name: cdr_gain_scheduler

Overview:
Controller that sequences the CDR loop-filter gain from fast acquisition to low-gain tracking.
- Observes bang-bang phase-detector votes (the same signed ±1 stream fed to the loop filter).
- Integrates the votes over fixed windows to judge lock, then steps gainsel down as lock is confirmed.
- Issues a one-cycle clear to the loop filter on start, and falls back to acquisition on loss of lock.
- Sits beside the loop filter in the RX CDR, driving its gainsel input.

Parameters:
WIN_LOG2, 6, log2 of votes per evaluation window (window = 64 valid votes)
LOCK_THR, 8, window is balanced when |net| <= LOCK_THR
LOCK_WINS, 4, consecutive balanced windows required to step gain down
UNLOCK_THR, 24, in TRACK, a window with |net| > UNLOCK_THR means lock is lost
GAIN_ACQ, 2'b11, gainsel in ACQ
GAIN_MID, 2'b10, gainsel in SETTLE
GAIN_TRK, 2'b01, gainsel in TRACK

Ports:
clk  in  1  block clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 runs the scheduler, 0 returns to IDLE
pd_valid  in  1  qualifies pd_err this cycle
pd_err  in  2  signed vote: 01=+1, 11=-1, 00=0, 10 treated as 0
gainsel  out  2  gain select to loop filter (registered)
lf_clear  out  1  one-cycle clear pulse to loop filter (registered)
locked  out  1  high only in TRACK (registered)
state  out  3  FSM state code for debug
win_net  out  WIN_LOG2+2  signed net vote sum of the last completed window

Behaviour:
- Reset values (asynchronous): state=IDLE, gainsel=2'b00, lf_clear=0, locked=0, win_net=0. Window counter, accumulator and balanced counter are all 0.
- State codes: IDLE=0, CLEAR=1, ACQ=2, SETTLE=3, TRACK=4.
- IDLE: gainsel=00. When enable=1, go to CLEAR on the next cycle.
- CLEAR: lasts exactly one cycle. lf_clear=1 during it, gainsel=GAIN_ACQ. Window counter, accumulator and balanced counter are zeroed. Always goes to ACQ.
- ACQ: gainsel=GAIN_ACQ.
  - After LOCK_WINS consecutive balanced windows, go to SETTLE.
- SETTLE: gainsel=GAIN_MID.
  - After LOCK_WINS consecutive balanced windows, go to TRACK.
- TRACK: gainsel=GAIN_TRK, locked=1.
  - A window with |net| > UNLOCK_THR goes to ACQ, with locked=0 and gainsel=GAIN_ACQ.
  - No lf_clear is issued on this fallback.
- enable=0 in any state: IDLE on the next cycle and all counters cleared. The loss of enable has priority over a window-end transition in the same cycle.
- Accumulation:
  - Accumulator is signed WIN_LOG2+2 bits (range ±2^WIN_LOG2, no overflow).
  - On pd_valid: acc += vote, and the window counter increments, wrapping at 2^WIN_LOG2.
  - pd_valid=0 leaves both unchanged.
- Window end: the cycle with pd_valid=1 and counter = 2^WIN_LOG2-1.
  - net = acc + current vote.
  - net is registered into win_net; acc is reset to 0.
  - The balanced test is applied to net.
  - Resulting state/gainsel/locked changes appear on the next clock edge, i.e. 1 cycle after window end.
- Balanced counter:
  - Increments on each balanced window, saturating at LOCK_WINS.
  - Clears on an unbalanced window and on every state change.
  - In TRACK, windows with LOCK_THR < |net| <= UNLOCK_THR hold state.
- Reset asserted mid-operation: all outputs immediately take reset values. No lf_clear pulse is generated by reset itself.

Optional Feature:
CDR_GAIN_OVERRIDE_EN
- Defined: adds input ports gain_ovr_en (1) and gain_ovr_val (2).
  - When gain_ovr_en=1, gainsel = gain_ovr_val (registered, 1-cycle latency) in every state except IDLE.
  - The FSM, locked and win_net continue unaffected.
- Undefined: ports absent; gainsel is driven solely by the FSM.

Test Plan:
- Reset 1 then 0, enable=0 -> gainsel=00, lf_clear=0, locked=0, state=0 indefinitely.
- enable=1 with alternating +1/-1 votes every cycle:
  - Next cycle state=1 and lf_clear=1 for exactly 1 cycle, then state=2 with gainsel=11.
  - After 4 windows (256 votes): gainsel=10.
  - After 4 more windows: gainsel=01, locked=1; win_net=0.
- In ACQ, constant +1 votes -> win_net=+64 each window, balanced count stays 0, gainsel remains 11.
- In TRACK, one window of constant -1 -> win_net=-64; 1 cycle after window end state=2, gainsel=11, locked=0, no lf_clear.
- In TRACK, a window with net=+16 -> stays TRACK, locked=1.
- enable dropped on a window-end cycle in SETTLE -> state=0, gainsel=00 next cycle. Re-enable -> CLEAR pulse and a fresh window starting from count 0.
